keypad_hex_entry: RTL and testbench

//   Input-side counterpart of the 7-segment display path. Scans a 4x4 matrix keypad, debounces it and

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_scanner.sv | 105 ++++++++++
 rtl/keypad_hex_entry.sv | 65 ++++++
 tb/tb_keypad_hex_entry.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Purpose: shared types and constants for the keypad hex-entry path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } scan_state_t;

  // Column 0 is driven first after reset.
  localparam logic [3:0] COL_INIT = 4'b1110;

  // Index of the lowest zero bit of an active-low vector. The lowest index wins,
  // so a multi-row press resolves to the lowest row.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 keypad column scanner with row synchronizer, scan divider, debounce FSM.
// Latency: key_pulse 1 clk after the accepting scan tick; rows see 2 clk of sync delay.
// Backpressure: none; key_pulse is a fire-and-forget strobe.
// Ports: clk, rst (sync, active-low), row_in[3:0] (async, active-low),
//        col_out[3:0] (active-low one-hot), key_pulse, key_code[3:0].
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_pulse,
  output logic [3:0] key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_TICKS);

  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  scan_state_t   state;
  logic [3:0]    cand_rows;
  logic [3:0]    cand_code;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rel_cnt;
  logic [3:0]    new_code;

  assign tick     = (div_cnt == DIV_MAX);
  assign new_code = {low_index(row_s), low_index(col_out)};

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      div_cnt   <= '0;
      state     <= SCAN;
      col_out   <= COL_INIT;
      cand_rows <= 4'hF;
      cand_code <= 4'h0;
      cnt       <= '0;
      rel_cnt   <= '0;
      key_pulse <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      row_m     <= row_in;
      row_s     <= row_m;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      key_pulse <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_s == 4'hF) begin
              col_out <= {col_out[2:0], col_out[3]};
            end else begin
              // Column is held from here until the key is released or rejected.
              cand_rows <= row_s;
              cand_code <= new_code;
              cnt       <= CW'(1);
              if (DEBOUNCE_TICKS == 1) begin
                key_pulse <= 1'b1;
                key_code  <= new_code;
                rel_cnt   <= '0;
                state     <= RELEASE;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (row_s == cand_rows) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == DB_MAX) begin
                key_pulse <= 1'b1;
                key_code  <= cand_code;
                rel_cnt   <= '0;
                state     <= RELEASE;
              end
            end else begin
              state <= SCAN;
            end
          end
          RELEASE: begin
            // Any low row restarts the release count; no auto-repeat.
            if (row_s == 4'hF) begin
              rel_cnt <= rel_cnt + 1'b1;
              if (rel_cnt + 1'b1 == DB_MAX) state <= SCAN;
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// Purpose: keypad hex entry; shifts digits into a 32-bit word and commits it on enter.
// Latency: entry/digit_count update on the edge an event is seen; out_valid 1 clk after enter.
// Backpressure: data_out held with out_valid until out_ready; enter ignored while out_valid.
// Ports: clk, rst (sync, active-low), row_in/col_out (keypad), btn_enter, btn_back,
//        key_pulse, key_code, entry, digit_count, data_out, out_valid, out_ready.
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        btn_enter,
  input  logic        btn_back,
  output logic        key_pulse,
  output logic [3:0]  key_code,
  output logic [31:0] entry,
  output logic [3:0]  digit_count,
  output logic [31:0] data_out,
  output logic        out_valid,
  input  logic        out_ready
);

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_pulse (key_pulse),
    .key_code  (key_code)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      entry       <= 32'h0;
      digit_count <= 4'd0;
      data_out    <= 32'h0;
      out_valid   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Priority enter > back > key; an ignored enter still swallows back/key.
      if (btn_enter) begin
        if (!out_valid) begin
          data_out    <= entry;
          out_valid   <= 1'b1;
          entry       <= 32'h0;
          digit_count <= 4'd0;
        end
      end else if (btn_back) begin
        entry <= entry >> 4;
        if (digit_count != 4'd0) digit_count <= digit_count - 1'b1;
      end else if (key_pulse) begin
        entry <= {entry[27:0], key_code};
        if (digit_count != 4'd8) digit_count <= digit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
module tb_keypad_hex_entry;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        btn_enter;
  logic        btn_back;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [31:0] entry;
  logic [3:0]  digit_count;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Physical keypad model
  logic       press_en  = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'hF;

  // Reference model: digits as a list, committed word and valid flag
  int unsigned     digits[$];
  logic [31:0]     m_data  = 32'h0;
  logic            m_valid = 1'b0;

  keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_TICKS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .btn_enter   (btn_enter),
    .btn_back    (btn_back),
    .key_pulse   (key_pulse),
    .key_code    (key_code),
    .entry       (entry),
    .digit_count (digit_count),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    if (force_en) row_in = force_val;
    else if (press_en && !col_out[press_col]) row_in[press_row] = 1'b0;
  end

  always @(posedge clk) if (key_pulse) pulses++;

  function automatic logic [31:0] model_word();
    logic [31:0] v;
    v = 32'h0;
    foreach (digits[i]) v = (v << 4) | 32'(digits[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, "_entry"}, entry, model_word());
    check({tag, "_count"}, 32'(digit_count), 32'(digits.size()));
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) check({tag, "_data"}, data_out, m_data);
  endtask

  task automatic check_rotation(input string tag);
    logic [3:0] prev;
    @(negedge clk);
    prev = col_out;
    repeat (4) @(negedge clk);
    check(tag, 32'(col_out), 32'({prev[2:0], prev[3]}));
  endtask

  task automatic press_key(input logic [3:0] k);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    press_row = k[3:2];
    press_col = k[1:0];
    press_en  = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (key_pulse) begin
        seen = 1;
        check("key_code", 32'(key_code), 32'(k));
      end
    end
    if (!seen) check("press_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    press_en = 1'b0;
    repeat (30) @(posedge clk);
    digits.push_back(int'(k));
    if (digits.size() > 8) void'(digits.pop_front());
  endtask

  task automatic pulse_btn(input bit en, input bit bk);
    @(posedge clk); #1;
    btn_enter = en;
    btn_back  = bk;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    if (en) begin
      if (!m_valid) begin
        m_data  = model_word();
        m_valid = 1'b1;
        digits.delete();
      end
    end else if (bk) begin
      if (digits.size() > 0) void'(digits.pop_back());
    end
  endtask

  task automatic accept_out(input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_hold"}, 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int p0;
    logic [3:0] k;
    bit found;
    rst = 1'b0; btn_enter = 1'b0; btn_back = 1'b0; out_ready = 1'b0;

    // 1: reset and column rotation
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_col", 32'(col_out), 32'(COL_INIT));
    check("rst_entry", entry, 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check_rotation("rotate_a");
    check_rotation("rotate_b");

    // 2: key 6 held for 20 ticks gives one pulse
    p0 = pulses;
    @(posedge clk); #1;
    press_row = 2'd1; press_col = 2'd2; press_en = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("hold_pulses", 32'(pulses - p0), 32'd1);
    check("hold_code", 32'(key_code), 32'd6);
    press_en = 1'b0;
    repeat (30) @(posedge clk);
    digits.push_back(6);
    check("key6_entry", entry, 32'h6);
    check_model("key6");

    // 3: one-tick bounce
    p0 = pulses;
    @(posedge clk); #1;
    force_val = 4'b1101; force_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 force_en = 1'b0;
    repeat (40) @(posedge clk);
    check("bounce_pulses", 32'(pulses - p0), 32'd0);
    check_rotation("bounce_rotate");

    // 4: keys 1..9 then back
    for (int i = 1; i <= 9; i++) press_key(4'(i));
    @(negedge clk);
    check("nine_entry", entry, 32'h23456789);
    check("nine_count", 32'(digit_count), 32'd8);
    pulse_btn(0, 1);
    @(negedge clk);
    check("back_entry", entry, 32'h02345678);
    check("back_count", 32'(digit_count), 32'd7);

    // 5: enter with backpressure, second enter ignored
    pulse_btn(1, 0);
    @(negedge clk);
    check("commit_valid", 32'(out_valid), 32'd1);
    check("commit_data", data_out, 32'h02345678);
    check("commit_entry", entry, 32'h0);
    k = 4'($urandom_range(1, 15));
    press_key(k);
    pulse_btn(1, 0);
    @(negedge clk);
    check("ignored_data", data_out, 32'h02345678);
    check("ignored_entry", entry, 32'(k));
    check_model("ignored");
    accept_out("hs1");

    // 6: enter and back together
    pulse_btn(0, 1);
    press_key(4'h1);
    press_key(4'h2);
    pulse_btn(1, 1);
    @(negedge clk);
    check("both_data", data_out, 32'h12);
    check("both_entry", entry, 32'h0);
    check_model("both");
    accept_out("hs2");

    // Randomized operations against the model
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0, 1: press_key(4'($urandom_range(0, 15)));
        2: pulse_btn(0, 1);
        default: pulse_btn(1, 0);
      endcase
      check_model("rand");
      if (m_valid && ($urandom_range(0, 1) == 1)) accept_out("rand_hs");
    end

    // Reset in the middle of a debounce
    if (!m_valid) pulse_btn(1, 0);
    press_key(4'($urandom_range(0, 15)));
    p0 = pulses;
    @(posedge clk); #1;
    press_row = 2'($urandom_range(0, 3)); press_col = 2'($urandom_range(0, 3)); press_en = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.u_scan.state == DEBOUNCE) found = 1;
    end
    if (!found) check("debounce_timeout", 32'd0, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_col", 32'(col_out), 32'(COL_INIT));
    check("mid_rst_pulse", 32'(key_pulse), 32'd0);
    check("mid_rst_code", 32'(key_code), 32'd0);
    check("mid_rst_entry", entry, 32'h0);
    check("mid_rst_count", 32'(digit_count), 32'd0);
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    press_en = 1'b0;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    check("mid_rst_pulses", 32'(pulses - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
